// File: rtl/body_param_commit.sv
// Frame-synchronous commit controller for the planet-parameter register file.
// Software fills a staging bank over Avalon-MM and requests a commit. On the
// next vertical-sync falling edge the staging bank is copied into the active
// bank one word per cycle, so renderers never see a half-updated frame.
module body_param_commit #(
    parameter int NUM_WORDS = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   AVL_CS,
    input  logic                   AVL_READ,
    input  logic                   AVL_WRITE,
    input  logic [3:0]             AVL_BYTE_EN,
    input  logic [3:0]             AVL_ADDR,
    input  logic [31:0]            AVL_WRITEDATA,
    output logic [31:0]            AVL_READDATA,
    input  logic                   VGA_VS,
    output logic [32*NUM_WORDS-1:0] ACT_WORDS,
    output logic                   ACT_VALID,
    output logic                   COMMIT_DONE
);

    localparam int              K_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [K_W-1:0]  LAST = K_W'(NUM_WORDS - 1);
    localparam logic [3:0]      NW4  = 4'(NUM_WORDS);

    typedef enum logic [1:0] {IDLE, ARMED, COPY} state_t;

    state_t          state, state_nxt;
    logic [K_W-1:0]  idx, idx_nxt;
    logic            pend, pend_nxt;

    logic [31:0]     stg [NUM_WORDS];
    logic            auto_en;
    logic            drop;
    logic [31:0]     frame_cnt;
    logic [15:0]     commit_cnt;

    logic            vs_p0, vs_p1, vs_p2;
    logic            fe_p3;

    logic            wr_en, ctrl_wr, commit_wr, clr_drop_wr, stg_hit;
    logic            copying, last_copy;

    assign wr_en       = AVL_CS & AVL_WRITE;
    // CTRL bits all live in byte 0, so byte 0 must be enabled to act on them.
    assign ctrl_wr     = wr_en & (AVL_ADDR == 4'd8) & AVL_BYTE_EN[0];
    assign commit_wr   = ctrl_wr & AVL_WRITEDATA[0];
    assign clr_drop_wr = ctrl_wr & AVL_WRITEDATA[2];
    assign stg_hit     = wr_en & (AVL_ADDR < NW4);
    assign copying     = (state == COPY);
    assign last_copy   = copying && (idx == LAST);
    assign ACT_VALID   = ~copying;

    // Synchronize VGA_VS and register a one-cycle pulse on its falling edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vs_p0 <= 1'b1;
            vs_p1 <= 1'b1;
            vs_p2 <= 1'b1;
            fe_p3 <= 1'b0;
        end else begin
            vs_p0 <= VGA_VS;
            vs_p1 <= vs_p0;
            vs_p2 <= vs_p1;
            fe_p3 <= vs_p2 & ~vs_p1;
        end
    end

    // FSM state, copy index and pending-commit flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            idx   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            pend  <= pend_nxt;
        end
    end

    // Next-state logic; a COMMIT write in IDLE wins over a coincident frame event.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pend_nxt  = pend;
        unique case (state)
            IDLE: begin
                if (commit_wr) begin
                    state_nxt = ARMED;
                end else if (fe_p3 && auto_en) begin
                    state_nxt = COPY;
                    idx_nxt   = '0;
                end
            end
            ARMED: begin
                if (fe_p3) begin
                    state_nxt = COPY;
                    idx_nxt   = '0;
                end
            end
            COPY: begin
                idx_nxt = idx + K_W'(1);
                if (commit_wr) pend_nxt = 1'b1;
                if (idx == LAST) begin
                    state_nxt = (pend || commit_wr) ? ARMED : IDLE;
                    pend_nxt  = 1'b0;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    // CTRL.AUTO and sticky DROP; a dropped write beats a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            auto_en <= 1'b0;
            drop    <= 1'b0;
        end else begin
            if (ctrl_wr) auto_en <= AVL_WRITEDATA[1];
            if (stg_hit && copying) drop <= 1'b1;
            else if (clr_drop_wr)   drop <= 1'b0;
        end
    end

    // Staging bank with per-byte writes, frozen while a copy is in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_WORDS; i++) stg[i] <= '0;
        end else if (stg_hit && !copying) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (AVL_ADDR == 4'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (AVL_BYTE_EN[b]) stg[i][8*b +: 8] <= AVL_WRITEDATA[8*b +: 8];
                    end
                end
            end
        end
    end

    // Active bank copy, done pulse and frame/commit counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ACT_WORDS   <= '0;
            COMMIT_DONE <= 1'b0;
            frame_cnt   <= '0;
            commit_cnt  <= '0;
        end else begin
            if (copying) begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    if (idx == K_W'(i)) ACT_WORDS[32*i +: 32] <= stg[i];
                end
            end
            COMMIT_DONE <= last_copy;
            if (last_copy) commit_cnt <= commit_cnt + 16'd1;
            if (fe_p3)     frame_cnt  <= frame_cnt + 32'd1;
        end
    end

    // Combinational Avalon read mux.
    always_comb begin
        AVL_READDATA = '0;
        if (AVL_CS && AVL_READ) begin
            case (AVL_ADDR)
                4'd8:    AVL_READDATA = {30'd0, auto_en, 1'b0};
                4'd9:    AVL_READDATA = {28'd0, pend, drop, copying, (state == ARMED)};
                4'd10:   AVL_READDATA = frame_cnt;
                4'd11:   AVL_READDATA = {16'd0, commit_cnt};
                default: begin
                    for (int i = 0; i < NUM_WORDS; i++) begin
                        if (AVL_ADDR == 4'(i)) AVL_READDATA = stg[i];
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/body_param_commit.md
# body_param_commit

Frame-synchronous commit controller for the planet-parameter register file. Software writes body radius and x/y/z words over Avalon-MM into a staging bank, then requests a commit. On the next vertical-sync event the block copies the staging bank into the active bank, one word per cycle, so the ball renderers never see a half-updated frame. It replaces the direct-write register file between the HPS Avalon bus and the ball renderer instances.

## Interface
- NUM_WORDS, 8, staging/active words (body0 R,X,Y,Z then body1 R,X,Y,Z); legal range 1..8.
- CLK  in  1  50 MHz system clock; all logic is on its rising edge.
- RESET  in  1  synchronous, active-high.
- AVL_CS, AVL_READ, AVL_WRITE  in  1 each  Avalon-MM slave strobes.
- AVL_BYTE_EN  in  4  per-byte write enable.
- AVL_ADDR  in  4  word address.
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  combinational read data; 0 unless AVL_CS && AVL_READ.
- VGA_VS  in  1  vertical sync from the VGA controller, active low, asynchronous to CLK.
- ACT_WORDS  out  32*NUM_WORDS  active bank; word i at [32i+31:32i]; registered.
- ACT_VALID  out  1  high when the active bank is coherent (low during COPY).
- COMMIT_DONE  out  1  one-cycle pulse after the last word is copied.

## Operation
- Address map:
  - 0..NUM_WORDS-1: staging R/W.
  - 8 CTRL: bit0 COMMIT (write-1 requests, reads 0); bit1 AUTO (R/W); bit2 CLR_DROP (write-1 clears DROP, reads 0).
  - 9 STATUS (RO): bit0 ARMED, bit1 COPYING, bit2 DROP, bit3 PEND.
  - 10 FRAME_CNT (RO, 32-bit).
  - 11 COMMIT_CNT (RO, [15:0], upper bits 0).
  - Other addresses read 0 and ignore writes. Writes to RO registers are ignored.
- Byte enables: each set bit independently updates its byte. Any combination is legal, including 0000 (no-op).
- Frame event (FE): VGA_VS passes through a 2-flop synchronizer. FE is a registered one-cycle pulse on the synchronized falling edge. FRAME_CNT increments on FE, wrapping at 2^32-1 -> 0.
- FSM states:
  - IDLE -> ARMED on a COMMIT write.
  - IDLE -> COPY on FE when AUTO=1.
  - ARMED -> COPY on FE.
  - COPY: index k=0..NUM_WORDS-1. Each cycle, active[k] <= staging[k] and k increments. After the last word -> ARMED if PEND else IDLE; PEND clears.
- COMMIT write while ARMED: no effect.
- COMMIT write while in COPY: sets PEND.
- FE while in COPY: ignored by the FSM; FRAME_CNT still increments.
- Staging writes while in COPY are dropped (no byte changes) and set sticky DROP. CTRL writes are always accepted.
- COMMIT_CNT increments (wraps at 16 bits) on the edge that copies the last word.
- Simultaneous COMMIT write and FE in IDLE: the FE is not consumed; the FSM goes to ARMED and waits for the next FE.
- Simultaneous CLR_DROP and a dropped write: DROP ends set.

## Timing
- Reset values:
  - All staging, active, counters, CTRL and STATUS = 0.
  - FSM = IDLE, synchronizer flops = 1.
  - ACT_VALID = 1, COMMIT_DONE = 0.
  - AVL_READDATA follows the combinational rule.
- Reset asserted mid-copy aborts the copy. The active bank returns to 0, not a partial copy.
- Write at edge t: visible on AVL_READDATA from the cycle after t.
- COMMIT write at edge t: STATUS.ARMED reads 1 from t+1.
- FE pulse is high at edge e: COPY spans edges e+1..e+NUM_WORDS. ACT_VALID is low for exactly NUM_WORDS cycles.
- COMMIT_DONE is high for the one cycle following the last copy edge.
- VGA_VS low held >= 3 CLK cycles produces exactly one FE.

## Test plan
- Reset, then read addresses 0..15 -> all 0. ACT_VALID=1, ACT_WORDS=0.
- Write 0x0000_0014 to addr 0, 0x0000_0140 to addr 1, BYTE_EN=1111. Then COMMIT, then drop VGA_VS for 10 cycles -> ACT_WORDS word0=0x14, word1=0x140. ACT_VALID low for 8 cycles. COMMIT_DONE pulses once. COMMIT_CNT=1.
- BYTE_EN=0100, write 0xAABBCCDD to addr 3 (previously 0x11223344) -> reads 0x11BB3344. Active bank is unchanged until a commit.
- Write to addr 2 during COPY -> staging unchanged, STATUS.DROP=1. CTRL write 0x4 -> DROP=0.
- AUTO=1 with 3 VS pulses and no COMMIT -> 3 commits; FRAME_CNT=3, COMMIT_CNT=3. COMMIT written during COPY -> PEND=1, then ARMED after the copy, then one more copy on the next FE.
- Assert RESET on the 4th copy cycle -> active bank all 0, FSM IDLE, no COMMIT_DONE pulse.
